// File: rtl/cpu_step_ctrl_pkg.sv
// rtl/cpu_step_ctrl_pkg.sv - shared state encoding and run-mode constants for the step controller
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_BURST = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam logic [1:0] MODE_STEP  = 2'b00;
  localparam logic [1:0] MODE_BURST = 2'b01;
  localparam logic [1:0] MODE_FREE  = 2'b10;
  localparam logic [1:0] MODE_BP    = 2'b11;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// rtl/cpu_step_ctrl_if.sv - control/status/display bundle between board logic and the step controller
interface cpu_step_ctrl_if #(
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8,
  parameter int NCH     = 4,
  parameter int SEL_W   = 2
) ();
  logic                step_btn;
  logic                run_btn;
  logic [1:0]          mode;
  logic [BURST_W-1:0]  burst_len;
  logic                bp_en;
  logic [PC_W-1:0]     bp_addr;
  logic [PC_W-1:0]     pc;
  logic [NCH*32-1:0]   ch_data;
  logic [SEL_W-1:0]    ch_sel;
  logic                cpu_ce;
  logic                busy;
  logic                bp_hit;
  logic [CNT_W-1:0]    cycle_cnt;
  logic [31:0]         disp_data;

  modport master (
    output step_btn, run_btn, mode, burst_len, bp_en, bp_addr, pc, ch_data, ch_sel,
    input  cpu_ce, busy, bp_hit, cycle_cnt, disp_data
  );

  modport slave (
    input  step_btn, run_btn, mode, burst_len, bp_en, bp_addr, pc, ch_data, ch_sel,
    output cpu_ce, busy, bp_hit, cycle_cnt, disp_data
  );
endinterface

// File: rtl/cpu_step_ctrl_edge_det.sv
// rtl/cpu_step_ctrl_edge_det.sv - rising-edge detector for a debounced button level
module cpu_step_ctrl_edge_det (
  input  logic clk,
  input  logic lvl_i,
  output logic rise_o
);
  logic lvl_q;

  // Follow the level every cycle, reset included, so a button held through reset never fires
  always_ff @(posedge clk) begin
    lvl_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~lvl_q;
endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - CPU clock-enable sequencer (step/burst/run/breakpoint) with counter and display mux
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8,
  parameter int NCH     = 4,
  parameter int SEL_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  cpu_step_ctrl_if.slave   bus
);
  state_e              state_q;
  logic [1:0]          mode_q;
  logic [BURST_W-1:0]  remaining_q;
  logic                armed_q;
  logic                bp_hit_q;
  logic [CNT_W-1:0]    cycle_cnt_q;
  logic [31:0]         disp_q;
  logic [31:0]         disp_d;
  logic [PC_W-1:0]     pc_cur;
  logic [PC_W-1:0]     bp_cur;
  logic                rise_step;
  logic                rise_run;
  logic                bp_stop;
  logic                cpu_ce;
  logic                run_mode;

  cpu_step_ctrl_edge_det u_step_edge (.clk(clk), .lvl_i(bus.step_btn), .rise_o(rise_step));
  cpu_step_ctrl_edge_det u_run_edge  (.clk(clk), .lvl_i(bus.run_btn),  .rise_o(rise_run));

  assign pc_cur   = bus.pc;
  assign bp_cur   = bus.bp_addr;
  assign run_mode = (bus.mode == MODE_FREE) || (bus.mode == MODE_BP);

  // Breakpoint gate is combinational so the instruction at bp_addr is never executed;
  // armed_q masks the first RUN cycle so a run can resume from the breakpoint PC
  assign bp_stop = (state_q == ST_RUN) && (mode_q == MODE_BP) && bus.bp_en && armed_q &&
                   (pc_cur == bp_cur);
  assign cpu_ce  = (state_q == ST_STEP) || (state_q == ST_BURST) ||
                   ((state_q == ST_RUN) && !bp_stop);

  // Execution FSM: mode is captured on leaving IDLE and held until the FSM returns there
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_STEP;
      remaining_q <= '0;
      armed_q     <= 1'b0;
      bp_hit_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_run && run_mode) begin
            state_q  <= ST_RUN;
            mode_q   <= bus.mode;
            armed_q  <= 1'b0;
            bp_hit_q <= 1'b0;
          end else if (rise_step && (bus.mode == MODE_STEP)) begin
            state_q <= ST_STEP;
            mode_q  <= bus.mode;
          end else if (rise_step && (bus.mode == MODE_BURST) && (bus.burst_len != '0)) begin
            state_q     <= ST_BURST;
            mode_q      <= bus.mode;
            remaining_q <= bus.burst_len;
          end
        end
        ST_STEP: begin
          state_q <= ST_IDLE;
        end
        ST_BURST: begin
          remaining_q <= remaining_q - 1'b1;
          if (rise_run || (remaining_q == BURST_W'(1))) begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          armed_q <= 1'b1;
          if (rise_run) begin
            state_q <= ST_IDLE;
          end else if (bp_stop) begin
            state_q  <= ST_IDLE;
            bp_hit_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Executed-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
    end else if (cpu_ce) begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
    end
  end

  // Channel select; selects beyond the populated channels show blank
  always_comb begin
    disp_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.ch_sel == SEL_W'(i)) begin
        disp_d = bus.ch_data[32*i +: 32];
      end
    end
  end

  // Registered display output for the seven-segment driver
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
    end else begin
      disp_q <= disp_d;
    end
  end

  assign bus.cpu_ce    = cpu_ce;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.bp_hit    = bp_hit_q;
  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.disp_data = disp_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - scoreboard bench for cpu_step_ctrl with a behavioural reference model
module tb_cpu_step_ctrl;
  localparam int PC_W    = 32;
  localparam int CNT_W   = 8;
  localparam int BURST_W = 8;
  localparam int NCH     = 3;
  localparam int SEL_W   = 2;

  logic clk;
  logic rst;

  cpu_step_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W), .BURST_W(BURST_W), .NCH(NCH), .SEL_W(SEL_W)) bus ();

  cpu_step_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .BURST_W(BURST_W), .NCH(NCH), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model view: "budget" = guaranteed ce cycles still owed (1 for a step, L for a burst);
  // "running" = an open-ended run; idle when neither holds.
  typedef struct {
    int          budget;
    bit          running;
    bit          bp_mode;
    bit          armed;
    bit          bp_hit;
    int          cnt;
    logic [31:0] disp;
  } snap_t;

  snap_t m;
  snap_t exp_q[$];
  bit    prev_s;
  bit    prev_r;
  int    total;
  int    bad;

  function automatic bit exp_ce(snap_t s);
    bit at_bp;
    at_bp = s.bp_mode && bus.bp_en && s.armed && (bus.pc == bus.bp_addr);
    return (s.budget > 0) || (s.running && !at_bp);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances on each edge from the rules, then plays the CPU by bumping pc per executed instruction
  always @(posedge clk) begin
    bit ce;
    bit rs;
    bit rr;
    bit stop;
    ce   = exp_ce(m);
    rs   = bus.step_btn && !prev_s;
    rr   = bus.run_btn && !prev_r;
    stop = m.bp_mode && bus.bp_en && m.armed && (bus.pc == bus.bp_addr);
    if (rst) begin
      m.budget  = 0;
      m.running = 1'b0;
      m.bp_mode = 1'b0;
      m.armed   = 1'b0;
      m.bp_hit  = 1'b0;
      m.cnt     = 0;
      m.disp    = '0;
    end else begin
      if (ce) m.cnt = (m.cnt + 1) % (1 << CNT_W);
      if (m.budget == 0 && !m.running) begin
        if (rr && bus.mode[1]) begin
          m.running = 1'b1;
          m.bp_mode = (bus.mode == 2'b11);
          m.armed   = 1'b0;
          m.bp_hit  = 1'b0;
        end else if (rs && bus.mode == 2'b00) begin
          m.budget = 1;
        end else if (rs && bus.mode == 2'b01 && bus.burst_len != 0) begin
          m.budget = int'(bus.burst_len);
        end
      end else if (m.budget > 0) begin
        m.budget = rr ? 0 : m.budget - 1;
      end else begin
        if (rr) m.running = 1'b0;
        else if (stop) begin
          m.running = 1'b0;
          m.bp_hit  = 1'b1;
        end else m.armed = 1'b1;
      end
      m.disp = (int'(bus.ch_sel) < NCH) ? bus.ch_data[32*int'(bus.ch_sel) +: 32] : 32'h0;
    end
    prev_s = bus.step_btn;
    prev_r = bus.run_btn;
    exp_q.push_back(m);
    #1;
    if (rst) bus.pc = '0;
    else if (ce) bus.pc = bus.pc + 32'd4;
  end

  // Monitor: pops the expectation for the current cycle and compares every output mid-cycle
  always @(negedge clk) begin
    snap_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cpu_ce",    64'(bus.cpu_ce),    64'(exp_ce(e)));
      check("busy",      64'(bus.busy),      64'((e.budget > 0) || e.running));
      check("bp_hit",    64'(bus.bp_hit),    64'(e.bp_hit));
      check("cycle_cnt", 64'(bus.cycle_cnt), 64'(e.cnt));
      check("disp_data", 64'(bus.disp_data), 64'(e.disp));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] tbl [4];

  initial begin
    total = 0;
    bad   = 0;
    tbl   = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h0};
    rst = 1'b1;
    bus.step_btn  = 1'b0;
    bus.run_btn   = 1'b0;
    bus.mode      = 2'b00;
    bus.burst_len = '0;
    bus.bp_en     = 1'b0;
    bus.bp_addr   = '0;
    bus.ch_data   = '0;
    bus.ch_sel    = '0;
    cyc(2);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_cnt",  64'(bus.cycle_cnt), 64'(0));
    check("rst_bphit", 64'(bus.bp_hit), 64'(0));
    check("rst_disp", 64'(bus.disp_data), 64'(0));
    rst = 1'b0;
    cyc(1);

    // three single steps
    for (int i = 0; i < 3; i++) begin
      bus.step_btn = 1'b1; cyc(1);
      bus.step_btn = 1'b0; cyc(1);
      cyc(2);
    end
    check("step_cnt", 64'(bus.cycle_cnt), 64'(3));

    // burst of 5, then burst_len 0 does nothing
    bus.mode = 2'b01; bus.burst_len = 8'd5;
    bus.step_btn = 1'b1; cyc(1);
    bus.step_btn = 1'b0; cyc(1);
    cyc(5);
    check("burst_cnt", 64'(bus.cycle_cnt), 64'(8));
    check("burst_idle", 64'(bus.busy), 64'(0));
    bus.burst_len = 8'd0;
    bus.step_btn = 1'b1; cyc(1);
    bus.step_btn = 1'b0; cyc(3);
    check("burst0_cnt", 64'(bus.cycle_cnt), 64'(8));

    // run to breakpoint at 0x0C, then resume and stop
    rst = 1'b1; cyc(1); rst = 1'b0;
    bus.mode = 2'b11; bus.bp_en = 1'b1; bus.bp_addr = 32'h0C;
    bus.run_btn = 1'b1; cyc(1);
    bus.run_btn = 1'b0; cyc(8);
    check("bp_cnt", 64'(bus.cycle_cnt), 64'(3));
    check("bp_hit", 64'(bus.bp_hit), 64'(1));
    check("bp_idle", 64'(bus.busy), 64'(0));
    bus.run_btn = 1'b1; cyc(1);
    bus.run_btn = 1'b0; cyc(1);
    check("resume_hit", 64'(bus.bp_hit), 64'(0));
    check("resume_busy", 64'(bus.busy), 64'(1));
    check("resume_cnt", 64'(bus.cycle_cnt), 64'(4));
    bus.run_btn = 1'b1; cyc(1);
    bus.run_btn = 1'b0; cyc(1);
    check("stop_busy", 64'(bus.busy), 64'(0));
    check("stop_cnt", 64'(bus.cycle_cnt), 64'(5));

    // free run, mode changed mid-run, counter wraps
    rst = 1'b1; cyc(1); rst = 1'b0;
    bus.mode = 2'b10;
    bus.run_btn = 1'b1; cyc(1);
    bus.run_btn = 1'b0; cyc(5);
    bus.mode = 2'b00; cyc(1);
    check("free_busy", 64'(bus.busy), 64'(1));
    cyc(300);
    bus.run_btn = 1'b1; cyc(1);
    bus.run_btn = 1'b0; cyc(1);
    check("free_stop", 64'(bus.busy), 64'(0));
    check("free_wrap", 64'(bus.cycle_cnt), 64'(307 % 256));

    // reset aborts a long burst; held button does not start one
    rst = 1'b1; cyc(1); rst = 1'b0;
    bus.mode = 2'b01; bus.burst_len = 8'd200;
    bus.step_btn = 1'b1; cyc(1);
    bus.step_btn = 1'b0; cyc(1);
    cyc(48);
    check("abort_pre_ce", 64'(bus.cpu_ce), 64'(1));
    rst = 1'b1; bus.step_btn = 1'b1; cyc(1);
    check("abort_ce", 64'(bus.cpu_ce), 64'(0));
    check("abort_cnt", 64'(bus.cycle_cnt), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    rst = 1'b0; cyc(3);
    check("held_busy", 64'(bus.busy), 64'(0));
    bus.step_btn = 1'b0; bus.mode = 2'b00; cyc(2);

    // display channel sweep
    bus.ch_data = {32'h33333333, 32'h22222222, 32'h11111111};
    for (int s = 0; s < 4; s++) begin
      bus.ch_sel = SEL_W'(s);
      cyc(1);
      check($sformatf("disp_sel%0d", s), 64'(bus.disp_data), 64'(tbl[s]));
    end

    // randomized traffic, scoreboard only
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)  bus.step_btn = ~bus.step_btn;
      if ($urandom_range(0, 15) == 0) bus.run_btn = ~bus.run_btn;
      if ($urandom_range(0, 31) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) bus.burst_len = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0) bus.bp_en = ~bus.bp_en;
      if ($urandom_range(0, 15) == 0) bus.bp_addr = bus.pc + 32'(4 * $urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0)  bus.ch_data = {$urandom, $urandom, $urandom};
      bus.ch_sel = SEL_W'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
